// File: rtl/ppi_pkg.sv
// Shared constants and types for the strobed PPI: control-word fields,
// port-C handshake bit positions and the power-on control value.
package ppi_pkg;

  localparam int CW_MODESET   = 7;
  localparam int CW_A_MODE_HI = 6;
  localparam int CW_A_MODE_LO = 5;
  localparam int CW_PA_IN     = 4;
  localparam int CW_PCU_IN    = 3;
  localparam int CW_B_MODE    = 2;
  localparam int CW_PB_IN     = 1;
  localparam int CW_PCL_IN    = 0;

  // PC2 doubles as STB_B_N / ACK_B_N / INTE_B, PC1 as IBF_B / OBF_B_N.
  localparam int PC_INTR_B = 0;
  localparam int PC_IBF_B  = 1;
  localparam int PC_STB_B  = 2;
  localparam int PC_INTR_A = 3;
  localparam int PC_STB_A  = 4;
  localparam int PC_IBF_A  = 5;
  localparam int PC_ACK_A  = 6;
  localparam int PC_OBF_A  = 7;

  localparam logic [7:0] CTRL_RESET = 8'h9B;

  typedef enum logic {
    MODE0 = 1'b0,
    MODE1 = 1'b1
  } ppi_mode_t;

  // Any non-zero group A mode field falls back to strobed mode 1.
  function automatic ppi_mode_t group_a_mode(input logic [1:0] field);
    return (field == 2'b00) ? MODE0 : MODE1;
  endfunction

endpackage

// File: rtl/ppi_in_fifo.sv
// Input FIFO for a strobed port; a pop frees room for a push in the same cycle.
module ppi_in_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ppi_strobed_io.sv
// Clocked 8255-style PPI with mode-1 strobed handshakes on ports A/B,
// per-port input FIFOs, interrupt requests and port-C bit set/reset.
module ppi_strobed_io
  import ppi_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 1,
  parameter int SYNC  = 2
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         CS_N,
  input  logic         RD_N,
  input  logic         WR_N,
  input  logic [1:0]   A,
  input  logic [W-1:0] D_IN,
  output logic [W-1:0] D_OUT,
  output logic         D_OE,
  input  logic [W-1:0] PA_IN,
  output logic [W-1:0] PA_OUT,
  output logic         PA_OE,
  input  logic [W-1:0] PB_IN,
  output logic [W-1:0] PB_OUT,
  output logic         PB_OE,
  input  logic [7:0]   PC_IN,
  output logic [7:0]   PC_OUT,
  output logic [7:0]   PC_OE,
  output logic         INTR_A,
  output logic         INTR_B
);

  logic [7:0]   ctrl, pc_latch;
  logic [W-1:0] pa_latch, pb_latch, last_a, last_b, rd_data;
  logic         wr_n_q, rd_n_q, wr_acc, rd_acc, mode_set, bsr;
  logic         inte_a, inte_b, obf_a_n, obf_b_n, intr_oa, intr_ob;
  logic [7:0]   sync_q [SYNC];
  logic [7:0]   pc_s;
  logic         stb_a_q, ack_a_q, hs_b_q;
  logic         a_in, b_in, a_sin, a_sout, b_sin, b_sout;
  ppi_mode_t    mode_a, mode_b;
  logic [W-1:0] head_a, head_b;
  logic         full_a, empty_a, full_b, empty_b;
  logic [7:0]   own, hs_oe, st, gen_oe, pc_rd;
  logic [2:0]   bsr_bit;

  assign wr_acc   = ~CS_N & ~WR_N & wr_n_q;
  assign rd_acc   = ~CS_N & ~RD_N & rd_n_q;
  assign mode_set = wr_acc & (A == 2'd3) & D_IN[CW_MODESET];
  assign bsr      = wr_acc & (A == 2'd3) & ~D_IN[CW_MODESET];
  assign bsr_bit  = D_IN[3:1];
  assign D_OE     = ~CS_N & ~RD_N;

  assign mode_a = group_a_mode(ctrl[CW_A_MODE_HI:CW_A_MODE_LO]);
  assign mode_b = ctrl[CW_B_MODE] ? MODE1 : MODE0;
  assign a_in   = ctrl[CW_PA_IN];
  assign b_in   = ctrl[CW_PB_IN];
  assign a_sin  = (mode_a == MODE1) & a_in;
  assign a_sout = (mode_a == MODE1) & ~a_in;
  assign b_sin  = (mode_b == MODE1) & b_in;
  assign b_sout = (mode_b == MODE1) & ~b_in;

  // PC pins are asynchronous; edges are taken only from the synchronised copy.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SYNC; i++) sync_q[i] <= '1;
      stb_a_q <= 1'b1;
      ack_a_q <= 1'b1;
      hs_b_q  <= 1'b1;
    end else begin
      sync_q[0] <= PC_IN;
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
      stb_a_q <= pc_s[PC_STB_A];
      ack_a_q <= pc_s[PC_ACK_A];
      hs_b_q  <= pc_s[PC_STB_B];
    end
  end
  assign pc_s = sync_q[SYNC-1];

  ppi_in_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_a (
    .clk(CLK), .rst_n(RESET_N), .flush(mode_set),
    .push(a_sin & stb_a_q & ~pc_s[PC_STB_A]),
    .pop(a_sin & rd_acc & (A == 2'd0)),
    .din(PA_IN), .dout(head_a), .full(full_a), .empty(empty_a)
  );

  ppi_in_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_b (
    .clk(CLK), .rst_n(RESET_N), .flush(mode_set),
    .push(b_sin & hs_b_q & ~pc_s[PC_STB_B]),
    .pop(b_sin & rd_acc & (A == 2'd1)),
    .din(PB_IN), .dout(head_b), .full(full_b), .empty(empty_b)
  );

  assign INTR_A = a_sin ? (inte_a & ~empty_a & pc_s[PC_STB_A]) : (a_sout & intr_oa);
  assign INTR_B = b_sin ? (inte_b & ~empty_b & pc_s[PC_STB_B]) : (b_sout & intr_ob);

  // Handshake-owned PC bits carry status; the rest behave as mode-0 nibbles.
  always_comb begin
    own   = '0;
    hs_oe = '0;
    st    = '0;
    if (mode_a == MODE1) begin
      own[PC_INTR_A]   = 1'b1;
      hs_oe[PC_INTR_A] = 1'b1;
      st[PC_INTR_A]    = INTR_A;
      if (a_in) begin
        own[PC_STB_A]   = 1'b1;
        own[PC_IBF_A]   = 1'b1;
        hs_oe[PC_IBF_A] = 1'b1;
        st[PC_STB_A]    = inte_a;
        st[PC_IBF_A]    = full_a;
      end else begin
        own[PC_ACK_A]   = 1'b1;
        own[PC_OBF_A]   = 1'b1;
        hs_oe[PC_OBF_A] = 1'b1;
        st[PC_ACK_A]    = inte_a;
        st[PC_OBF_A]    = obf_a_n;
      end
    end
    if (mode_b == MODE1) begin
      own[PC_INTR_B]   = 1'b1;
      own[PC_IBF_B]    = 1'b1;
      own[PC_STB_B]    = 1'b1;
      hs_oe[PC_INTR_B] = 1'b1;
      hs_oe[PC_IBF_B]  = 1'b1;
      st[PC_INTR_B]    = INTR_B;
      st[PC_IBF_B]     = b_in ? full_b : obf_b_n;
      st[PC_STB_B]     = inte_b;
    end
  end

  assign gen_oe = {{4{~ctrl[CW_PCU_IN]}}, {4{~ctrl[CW_PCL_IN]}}};
  assign PC_OE  = (own & hs_oe) | (~own & gen_oe);
  assign PC_OUT = (own & hs_oe & st) | (~own & pc_latch);
  assign pc_rd  = (own & st) | (~own & ((gen_oe & pc_latch) | (~gen_oe & pc_s)));

  assign PA_OUT = pa_latch;
  assign PB_OUT = pb_latch;
  assign PA_OE  = ~a_in;
  assign PB_OE  = ~b_in;

  // An empty strobed FIFO returns the last word popped from it.
  always_comb begin
    rd_data = '0;
    case (A)
      2'd0:    rd_data = a_sin ? (empty_a ? last_a : head_a) : (a_in ? PA_IN : pa_latch);
      2'd1:    rd_data = b_sin ? (empty_b ? last_b : head_b) : (b_in ? PB_IN : pb_latch);
      2'd2:    rd_data = W'(pc_rd);
      default: rd_data = W'(ctrl);
    endcase
  end

  // Later assignments win: bus writes override ACK events, mode set overrides all.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl     <= CTRL_RESET;
      pa_latch <= '0;
      pb_latch <= '0;
      pc_latch <= '0;
      last_a   <= '0;
      last_b   <= '0;
      D_OUT    <= '0;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      inte_a   <= 1'b0;
      inte_b   <= 1'b0;
      obf_a_n  <= 1'b1;
      obf_b_n  <= 1'b1;
      intr_oa  <= 1'b0;
      intr_ob  <= 1'b0;
    end else begin
      wr_n_q <= WR_N;
      rd_n_q <= RD_N;
      if (rd_acc) begin
        D_OUT <= rd_data;
        if (a_sin && A == 2'd0 && !empty_a) last_a <= head_a;
        if (b_sin && A == 2'd1 && !empty_b) last_b <= head_b;
      end
      if (a_sout) begin
        if (ack_a_q && !pc_s[PC_ACK_A])          obf_a_n <= 1'b1;
        if (!ack_a_q && pc_s[PC_ACK_A] && inte_a) intr_oa <= 1'b1;
      end
      if (b_sout) begin
        if (hs_b_q && !pc_s[PC_STB_B])          obf_b_n <= 1'b1;
        if (!hs_b_q && pc_s[PC_STB_B] && inte_b) intr_ob <= 1'b1;
      end
      if (mode_set) begin
        ctrl     <= D_IN[7:0];
        pa_latch <= '0;
        pb_latch <= '0;
        pc_latch <= '0;
        last_a   <= '0;
        last_b   <= '0;
        inte_a   <= 1'b0;
        inte_b   <= 1'b0;
        obf_a_n  <= 1'b1;
        obf_b_n  <= 1'b1;
        intr_oa  <= 1'b0;
        intr_ob  <= 1'b0;
      end else if (bsr) begin
        if (!own[bsr_bit]) begin
          pc_latch[bsr_bit] <= D_IN[0];
        end else begin
          if ((a_sin && bsr_bit == 3'(PC_STB_A)) || (a_sout && bsr_bit == 3'(PC_ACK_A)))
            inte_a <= D_IN[0];
          if (mode_b == MODE1 && bsr_bit == 3'(PC_STB_B))
            inte_b <= D_IN[0];
        end
      end else if (wr_acc) begin
        case (A)
          2'd0: begin
            pa_latch <= D_IN;
            if (a_sout) begin
              obf_a_n <= 1'b0;
              intr_oa <= 1'b0;
            end
          end
          2'd1: begin
            pb_latch <= D_IN;
            if (b_sout) begin
              obf_b_n <= 1'b0;
              intr_ob <= 1'b0;
            end
          end
          default: pc_latch <= D_IN[7:0];
        endcase
      end
    end
  end

endmodule
